// File: rtl/video_timing_scheduler.sv
// Frame-level HDMI timing scheduler: sequences back porch / active / front porch / sync
// per line and per frame, with mode changes staged in a pending slot and applied at frame wrap.
module video_timing_scheduler #(
   parameter int unsigned W         = 12,
   parameter logic        HSYNC_POL = 1'b1,
   parameter logic        VSYNC_POL = 1'b1
) (
   input  logic         clock_50,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_h_bp,
   input  logic [W-1:0] cfg_h_active,
   input  logic [W-1:0] cfg_h_fp,
   input  logic [W-1:0] cfg_h_sync,
   input  logic [W-1:0] cfg_v_bp,
   input  logic [W-1:0] cfg_v_active,
   input  logic [W-1:0] cfg_v_fp,
   input  logic [W-1:0] cfg_v_sync,
   output logic         cfg_error,
   output logic         hsync,
   output logic         vsync,
   output logic         de,
   output logic [W-1:0] pixel_x,
   output logic [W-1:0] pixel_y,
   output logic         line_start,
   output logic         frame_start,
   output logic         busy
);
   localparam int TW = W + 2;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   typedef struct packed {
      logic [W-1:0] h_bp;
      logic [W-1:0] h_act;
      logic [W-1:0] h_fp;
      logic [W-1:0] h_sync;
      logic [W-1:0] v_bp;
      logic [W-1:0] v_act;
      logic [W-1:0] v_fp;
      logic [W-1:0] v_sync;
   } cfg_t;

   function automatic logic [TW-1:0] total4(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
      return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
   endfunction

   state_t        r_state, w_state_next;
   cfg_t          r_act, r_pend, w_cfg_in, w_use;
   logic          r_act_valid, r_pend_valid;
   logic [W-1:0]  r_h_cnt, r_v_cnt, w_h_next, w_v_next;
   logic          r_cfg_ready, r_cfg_error, r_hsync, r_vsync, r_de;
   logic          r_line_start, r_frame_start, r_busy;
   logic [W-1:0]  r_pixel_x, r_pixel_y;

   logic [TW-1:0] w_h_tot_in, w_v_tot_in, w_h_tot_act, w_v_tot_act;
   logic [TW-1:0] w_h_tot_use, w_v_tot_use, w_hn, w_vn;
   logic          w_cfg_ok, w_hs, w_accept, w_reject, w_copy;
   logic          w_h_last, w_v_last, w_wrap, w_advance, w_run_next;
   logic          w_h_act_n, w_v_act_n, w_de_n, w_hs_on, w_vs_on;

   assign w_cfg_in = '{h_bp: cfg_h_bp, h_act: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync,
                       v_bp: cfg_v_bp, v_act: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync};

   // Totals are summed wide enough that four maximal fields cannot wrap into a legal value.
   assign w_h_tot_in = total4(cfg_h_bp, cfg_h_active, cfg_h_fp, cfg_h_sync);
   assign w_v_tot_in = total4(cfg_v_bp, cfg_v_active, cfg_v_fp, cfg_v_sync);
   assign w_cfg_ok   = (cfg_h_bp != '0) && (cfg_h_active != '0) && (cfg_h_fp != '0) &&
                       (cfg_h_sync != '0) && (cfg_v_bp != '0) && (cfg_v_active != '0) &&
                       (cfg_v_fp != '0) && (cfg_v_sync != '0) &&
                       (w_h_tot_in < (TW'(1) << W)) && (w_v_tot_in < (TW'(1) << W));
   assign w_hs       = cfg_valid && r_cfg_ready;
   assign w_accept   = w_hs && w_cfg_ok;
   assign w_reject   = w_hs && !w_cfg_ok;

   assign w_h_tot_act = total4(r_act.h_bp, r_act.h_act, r_act.h_fp, r_act.h_sync);
   assign w_v_tot_act = total4(r_act.v_bp, r_act.v_act, r_act.v_fp, r_act.v_sync);
   assign w_h_last    = ({2'b00, r_h_cnt} + TW'(1)) == w_h_tot_act;
   assign w_v_last    = ({2'b00, r_v_cnt} + TW'(1)) == w_v_tot_act;
   assign w_wrap      = (r_state != ST_IDLE) && w_h_last && w_v_last;
   assign w_copy      = r_pend_valid && ((r_state == ST_IDLE) || w_wrap);

   always_comb begin
      w_state_next = r_state;
      w_advance    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && (r_act_valid || r_pend_valid)) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_advance = 1'b1;
            if (!enable) w_state_next = w_wrap ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            w_advance = 1'b1;
            if (enable)      w_state_next = ST_RUN;
            else if (w_wrap) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_run_next = (w_state_next != ST_IDLE);

   always_comb begin
      w_h_next = '0;
      w_v_next = '0;
      if (w_advance && w_run_next) begin
         w_h_next = w_h_last ? '0 : r_h_cnt + W'(1);
         if (w_h_last) w_v_next = w_v_last ? '0 : r_v_cnt + W'(1);
         else          w_v_next = r_v_cnt;
      end
   end

   // Outputs describe the next (h,v) under whichever mode will be active after this edge.
   assign w_use       = w_copy ? r_pend : r_act;
   assign w_h_tot_use = total4(w_use.h_bp, w_use.h_act, w_use.h_fp, w_use.h_sync);
   assign w_v_tot_use = total4(w_use.v_bp, w_use.v_act, w_use.v_fp, w_use.v_sync);
   assign w_hn        = {2'b00, w_h_next};
   assign w_vn        = {2'b00, w_v_next};
   assign w_h_act_n   = (w_hn >= {2'b00, w_use.h_bp}) &&
                        (w_hn < ({2'b00, w_use.h_bp} + {2'b00, w_use.h_act}));
   assign w_v_act_n   = (w_vn >= {2'b00, w_use.v_bp}) &&
                        (w_vn < ({2'b00, w_use.v_bp} + {2'b00, w_use.v_act}));
   assign w_de_n      = w_run_next && w_h_act_n && w_v_act_n;
   assign w_hs_on     = w_run_next && (w_hn >= (w_h_tot_use - {2'b00, w_use.h_sync}));
   assign w_vs_on     = w_run_next && (w_vn >= (w_v_tot_use - {2'b00, w_use.v_sync}));

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_act         <= '0;
         r_pend        <= '0;
         r_act_valid   <= 1'b0;
         r_pend_valid  <= 1'b0;
         r_cfg_ready   <= 1'b1;
         r_cfg_error   <= 1'b0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_h_cnt       <= w_h_next;
         r_v_cnt       <= w_v_next;
         r_cfg_error   <= w_reject;
         r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
         r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
         r_de          <= w_de_n;
         r_pixel_x     <= w_de_n ? (w_h_next - w_use.h_bp) : '0;
         r_pixel_y     <= w_de_n ? (w_v_next - w_use.v_bp) : '0;
         r_line_start  <= w_run_next && (w_h_next == '0);
         r_frame_start <= w_run_next && (w_h_next == '0) && (w_v_next == '0);
         r_busy        <= w_run_next;
         // Copy and accept never coincide: a handshake needs an empty pending slot.
         if (w_copy) begin
            r_act        <= r_pend;
            r_act_valid  <= 1'b1;
            r_pend_valid <= 1'b0;
            r_cfg_ready  <= 1'b1;
         end else if (w_accept) begin
            r_pend       <= w_cfg_in;
            r_pend_valid <= 1'b1;
            r_cfg_ready  <= 1'b0;
         end
      end
   end

   assign cfg_ready   = r_cfg_ready;
   assign cfg_error   = r_cfg_error;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign busy        = r_busy;

endmodule

// File: tb/tb_video_timing_scheduler.sv
// Scoreboard bench for video_timing_scheduler: expected per-frame statistics are queued by
// the stimulus and compared by a monitor each time a frame completes.
module tb_video_timing_scheduler;
   localparam int   W      = 12;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b1;

   logic         clock_50 = 1'b0;
   logic         reset_n, enable, cfg_valid;
   logic         cfg_ready, cfg_error, hsync, vsync, de, line_start, frame_start, busy;
   logic [W-1:0] cfg_h_bp, cfg_h_active, cfg_h_fp, cfg_h_sync;
   logic [W-1:0] cfg_v_bp, cfg_v_active, cfg_v_fp, cfg_v_sync;
   logic [W-1:0] pixel_x, pixel_y;

   video_timing_scheduler #(.W(W), .HSYNC_POL(HS_POL), .VSYNC_POL(VS_POL)) dut (
      .clock_50(clock_50), .reset_n(reset_n), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_h_bp(cfg_h_bp), .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync),
      .cfg_v_bp(cfg_v_bp), .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync),
      .cfg_error(cfg_error), .hsync(hsync), .vsync(vsync), .de(de),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .line_start(line_start), .frame_start(frame_start), .busy(busy)
   );

   always #5 clock_50 = ~clock_50;

   typedef struct {
      int line_len;
      int frame_len;
      int de_n;
      int hs_n;
      int vs_n;
      int max_x;
      int max_y;
      int coord_ok;
   } frame_t;

   frame_t q_frame[$];
   int n_err = 0;
   int n_chk = 0;

   // Monitor state
   int m_in_frame = 0, m_n, m_last_ls, m_ll, m_lines_bad, m_de, m_hs, m_vs;
   int m_max_x, m_max_y, m_de_x, m_act_line, m_line_de, m_coord_bad;
   int frames_done = 0, ls_total = 0, err_pulses = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic frame_t mk(input int ll, input int fl, input int d, input int h,
                                 input int v, input int mx, input int my);
      frame_t f;
      f.line_len = ll; f.frame_len = fl; f.de_n = d; f.hs_n = h;
      f.vs_n = v; f.max_x = mx; f.max_y = my; f.coord_ok = 1;
      return f;
   endfunction

   // Hand-derived: mode A is h=4/8/2/3 (17), v=1/4/1/2 (8); mode B widens h_active to 16 (25).
   frame_t fr_a, fr_b;
   initial begin
      fr_a = mk(17, 136, 32, 24, 34, 7, 3);
      fr_b = mk(25, 200, 64, 24, 50, 15, 3);
   end

   task automatic note_interval(input int iv);
      if (m_ll < 0) m_ll = iv;
      else if (iv != m_ll) m_lines_bad = 1;
   endtask

   task automatic finalize();
      frame_t e;
      note_interval(m_n - m_last_ls);
      frames_done++;
      $display("frame %0d: line=%0d len=%0d de=%0d hs=%0d vs=%0d max_x=%0d max_y=%0d",
               frames_done, m_lines_bad ? -1 : m_ll, m_n, m_de, m_hs, m_vs, m_max_x, m_max_y);
      if (q_frame.size() == 0) begin
         chk("unexpected_frame", frames_done, 0);
      end else begin
         e = q_frame.pop_front();
         chk("line_len",  m_lines_bad ? -1 : m_ll, e.line_len);
         chk("frame_len", m_n,      e.frame_len);
         chk("de_cycles", m_de,     e.de_n);
         chk("hsync_cycles", m_hs,  e.hs_n);
         chk("vsync_cycles", m_vs,  e.vs_n);
         chk("max_pixel_x", m_max_x, e.max_x);
         chk("max_pixel_y", m_max_y, e.max_y);
         chk("coords_ok", m_coord_bad ? 0 : 1, e.coord_ok);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock_50);
         if (!reset_n) begin
            m_in_frame = 0;
         end else begin
            if (frame_start) begin
               if (m_in_frame != 0) finalize();
               m_in_frame = 1; m_n = 0; m_last_ls = 0; m_ll = -1; m_lines_bad = 0;
               m_de = 0; m_hs = 0; m_vs = 0; m_max_x = 0; m_max_y = 0;
               m_de_x = 0; m_act_line = 0; m_line_de = 0; m_coord_bad = 0;
            end else if (m_in_frame != 0 && !busy) begin
               finalize();
               m_in_frame = 0;
            end
            if (line_start) ls_total++;
            if (cfg_error) err_pulses++;
            if (m_in_frame != 0) begin
               if (line_start) begin
                  if (m_n > 0) note_interval(m_n - m_last_ls);
                  m_last_ls = m_n;
                  if (m_line_de != 0) m_act_line++;
                  m_line_de = 0;
                  m_de_x = 0;
               end
               if (de) begin
                  m_de++;
                  if (int'(pixel_x) > m_max_x) m_max_x = int'(pixel_x);
                  if (int'(pixel_y) > m_max_y) m_max_y = int'(pixel_y);
                  if (int'(pixel_x) != m_de_x || int'(pixel_y) != m_act_line) m_coord_bad = 1;
                  m_de_x++;
                  m_line_de = 1;
               end else if (pixel_x != '0 || pixel_y != '0) begin
                  m_coord_bad = 1;
               end
               if (hsync == HS_POL) m_hs++;
               if (vsync == VS_POL) m_vs++;
               m_n++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock_50);
      #1;
   endtask

   task automatic offer(input int hbp, input int hact, input int hfp, input int hs,
                        input int vbp, input int vact, input int vfp, input int vs);
      cfg_h_bp = W'(hbp); cfg_h_active = W'(hact); cfg_h_fp = W'(hfp); cfg_h_sync = W'(hs);
      cfg_v_bp = W'(vbp); cfg_v_active = W'(vact); cfg_v_fp = W'(vfp); cfg_v_sync = W'(vs);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      $display("cfg offer h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d -> ready=%0b error=%0b",
               hbp, hact, hfp, hs, vbp, vact, vfp, vs, cfg_ready, cfg_error);
   endtask

   task automatic wait_fs(input string tag);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!frame_start && k < 400);
      chk(tag, int'(frame_start), 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
      chk({tag, "_cfg_error"}, int'(cfg_error), 0);
      chk({tag, "_hsync"}, int'(hsync), int'(!HS_POL));
      chk({tag, "_vsync"}, int'(vsync), int'(!VS_POL));
      chk({tag, "_de"}, int'(de), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_ls_fs"}, int'({line_start, frame_start}), 0);
      chk({tag, "_pixel"}, int'({pixel_x, pixel_y}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, ls_snap, prev_ready;
      reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
      cfg_h_bp = '0; cfg_h_active = '0; cfg_h_fp = '0; cfg_h_sync = '0;
      cfg_v_bp = '0; cfg_v_active = '0; cfg_v_fp = '0; cfg_v_sync = '0;
      repeat (3) @(posedge clock_50);
      #1;
      chk_reset_vals("por");
      reset_n = 1'b1;
      tick();

      // Load mode A in IDLE, then start and run three full frames.
      offer(4, 8, 2, 3, 1, 4, 1, 2);
      chk("ready_drop_idle", int'(cfg_ready), 0);
      tick();
      chk("ready_rise_idle", int'(cfg_ready), 1);
      chk("idle_not_busy", int'(busy), 0);
      repeat (3) q_frame.push_back(fr_a);
      enable = 1'b1;
      tick();
      chk("startup_frame_start", int'(frame_start), 1);
      chk("startup_busy", int'(busy), 1);
      repeat (3) wait_fs("run_frame_start");

      // Mid-frame reset during line 2 (v=1, h=5): outputs must drop without a clock edge.
      repeat (22) tick();
      chk("pre_reset_de", int'(de), 1);
      chk("pre_reset_pixel_x", int'(pixel_x), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clock_50);
      #1;
      reset_n = 1'b1;
      repeat (5) tick();
      chk("no_start_without_cfg", int'(busy), 0);

      // Handshake at N with enable already high starts at N+1.
      q_frame.push_back(fr_a);
      offer(4, 8, 2, 3, 1, 4, 1, 2);
      chk("no_start_at_handshake", int'(frame_start | busy), 0);
      tick();
      chk("start_after_load", int'(frame_start), 1);

      // Frame-boundary switch to mode B.
      repeat (20) tick();
      offer(4, 16, 2, 3, 1, 4, 1, 2);
      chk("ready_drop_run", int'(cfg_ready), 0);
      q_frame.push_back(fr_b);
      q_frame.push_back(fr_b);
      k = 0;
      prev_ready = int'(cfg_ready);
      while (!frame_start && k < 400) begin
         prev_ready = int'(cfg_ready);
         tick();
         k++;
      end
      chk("switch_frame_start", int'(frame_start), 1);
      chk("ready_low_before_switch", prev_ready, 0);
      chk("ready_rise_at_switch", int'(cfg_ready), 1);

      // Rejected offers leave the timing alone.
      repeat (10) tick();
      offer(4, 8, 2, 3, 1, 4, 1, 0);
      chk("reject_vsync0_error", int'(cfg_error), 1);
      chk("reject_vsync0_ready", int'(cfg_ready), 1);
      tick();
      chk("error_single_pulse", int'(cfg_error), 0);
      offer(1000, 2000, 1000, 96, 1, 4, 1, 2);
      chk("reject_htotal_error", int'(cfg_error), 1);
      chk("reject_htotal_ready", int'(cfg_ready), 1);
      wait_fs("frame_after_reject");

      // Back to mode A, then drain in line 3 and resume before the wrap.
      offer(4, 8, 2, 3, 1, 4, 1, 2);
      chk("ready_drop_back_to_a", int'(cfg_ready), 0);
      q_frame.push_back(fr_a);
      wait_fs("frame_mode_a");
      repeat (37) tick();
      enable = 1'b0;
      repeat (20) tick();
      chk("busy_in_drain", int'(busy), 1);
      enable = 1'b1;
      q_frame.push_back(fr_a);
      wait_fs("frame_after_resume");

      // Final drain: busy falls right after the last pixel of the frame.
      repeat (10) tick();
      enable = 1'b0;
      k = 10;
      while (busy && k < 400) begin
         tick();
         k++;
      end
      chk("busy_fall_cycle", k, 136);
      chk("idle_hsync", int'(hsync), int'(!HS_POL));
      chk("idle_vsync", int'(vsync), int'(!VS_POL));
      ls_snap = ls_total;
      repeat (60) tick();
      chk("no_line_start_idle", ls_total, ls_snap);
      chk("scoreboard_empty", q_frame.size(), 0);
      chk("cfg_error_pulses", err_pulses, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
